// File: rtl/binary_subtractor_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : binary_subtractor_seq_pkg
//  Brief    : Shared state encoding and default sizing for the serial subtractor.
//  Revision : 1.0
// ============================================================================
package binary_subtractor_seq_pkg;

    localparam int c_DEFAULT_WIDTH = 100;
    localparam int c_DEFAULT_CHUNK = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/binary_subtractor_seq_chunk_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : chunk_subtractor
//  Brief    : Combinational CHUNK-bit subtract with borrow-in and borrow-out.
//  Revision : 1.0
// ============================================================================
module chunk_subtractor #(
    parameter int CHUNK = 10
) (
    input  logic [CHUNK-1:0] i_x,
    input  logic [CHUNK-1:0] i_y,
    input  logic             i_bin,
    output logic [CHUNK-1:0] o_diff,
    output logic             o_bout
);

    // One extra bit captures the sign of x - y - bin, which is the borrow-out.
    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_x} - {1'b0, i_y} - {{CHUNK{1'b0}}, i_bin};
    assign o_diff = w_full[CHUNK-1:0];
    assign o_bout = w_full[CHUNK];

endmodule
`default_nettype wire

// File: rtl/binary_subtractor_seq.sv
`default_nettype none
// ============================================================================
//  Module   : binary_subtractor_seq
//  Brief    : Multi-cycle WIDTH-bit subtractor, CHUNK bits per cycle, valid/ready.
//  Revision : 1.0
// ============================================================================
module binary_subtractor_seq
    import binary_subtractor_seq_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int CHUNK = c_DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int c_N     = WIDTH / CHUNK;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N - 1);

    state_t             r_state_q,  w_state_d;
    logic [WIDTH-1:0]   r_a_q,      w_a_d;
    logic [WIDTH-1:0]   r_b_q,      w_b_d;
    logic [WIDTH-1:0]   r_diff_q,   w_diff_d;
    logic               r_bout_q,   w_bout_d;
    logic               r_borrow_q, w_borrow_d;
    logic [c_IDX_W-1:0] r_idx_q,    w_idx_d;

    logic [c_POS_W-1:0] w_base;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_chunk_diff;
    logic               w_chunk_bout;

    assign w_base    = c_POS_W'(int'(r_idx_q) * CHUNK);
    assign w_a_chunk = r_a_q[w_base +: CHUNK];
    assign w_b_chunk = r_b_q[w_base +: CHUNK];

    chunk_subtractor #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_x    (w_a_chunk),
        .i_y    (w_b_chunk),
        .i_bin  (r_borrow_q),
        .o_diff (w_chunk_diff),
        .o_bout (w_chunk_bout)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_diff_d   = r_diff_q;
        w_bout_d   = r_bout_q;
        w_borrow_d = r_borrow_q;
        w_idx_d    = r_idx_q;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_a_d      = a;
                    w_b_d      = b;
                    w_borrow_d = bin;
                    w_idx_d    = '0;
                    w_state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_diff_d[w_base +: CHUNK] = w_chunk_diff;
                w_borrow_d                = w_chunk_bout;
                if (r_idx_q == c_LAST_IDX) begin
                    w_idx_d   = '0;
                    w_bout_d  = w_chunk_bout;
                    w_state_d = ST_DONE;
                end else begin
                    w_idx_d = r_idx_q + c_IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_diff_q   <= '0;
            r_bout_q   <= 1'b0;
            r_borrow_q <= 1'b0;
            r_idx_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_diff_q   <= w_diff_d;
            r_bout_q   <= w_bout_d;
            r_borrow_q <= w_borrow_d;
            r_idx_q    <= w_idx_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = (r_state_q == ST_DONE);
    assign diff      = r_diff_q;
    assign bout      = r_bout_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_subtractor_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_binary_subtractor_seq
//  Brief    : Self-checking bench for binary_subtractor_seq against an arithmetic model.
//  Revision : 1.0
// ============================================================================
module tb_binary_subtractor_seq;

    localparam int W   = 100;
    localparam int C   = 10;
    localparam int LAT = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic         bin;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         out_valid;
    logic         out_ready;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    binary_subtractor_seq #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [W-1:0] rand_wide();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Reference: {borrow, difference} from whole-width unsigned arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
        logic [W-1:0] d;
        logic         bo;
        d  = ma - mb - W'(mbin);
        bo = ({1'b0, mb} + (W+1)'(mbin)) > {1'b0, ma};
        return {bo, d};
    endfunction

    // Apply one operation, scramble inputs while busy, return result and latency.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          output logic [W-1:0] od, output logic obo, output int lat);
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = -1;
        for (int i = 1; i <= 4 * LAT; i++) begin
            a   = rand_wide();
            b   = rand_wide();
            bin = 1'($urandom());
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
            in_valid = 1'($urandom());
        end
        in_valid  = 1'b0;
        od        = diff;
        obo       = bout;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = rand_wide(); b = rand_wide(); bin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        vectors++;
        if (diff !== '0) begin
            miscompares++; $display("FAIL reset_diff got=%h exp=0", diff);
        end
        vectors++;
        if (bout !== 1'b0) begin
            miscompares++; $display("FAIL reset_bout got=%b exp=0", bout);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[4], vb[4], ed[4], got_d, ones, p99;
        logic         vbin[4], eb[4], got_b;
        int           lat;
        ones = '1;
        p99  = '0;
        p99[W-1] = 1'b1;
        va[0] = W'(5000); vb[0] = W'(1234); vbin[0] = 1'b0; ed[0] = W'(3766);  eb[0] = 1'b0;
        va[1] = '0;       vb[1] = W'(1);    vbin[1] = 1'b0; ed[1] = ones;      eb[1] = 1'b1;
        va[2] = ones;     vb[2] = ones;     vbin[2] = 1'b1; ed[2] = ones;      eb[2] = 1'b1;
        va[3] = p99;      vb[3] = W'(1);    vbin[3] = 1'b0; ed[3] = p99 - 1'b1; eb[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vbin[i], got_d, got_b, lat);
            vectors++;
            if (lat !== LAT) begin
                miscompares++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, LAT);
            end
            vectors++;
            if (got_d !== ed[i]) begin
                miscompares++; $display("FAIL directed%0d_diff got=%h exp=%h", i, got_d, ed[i]);
            end
            vectors++;
            if (got_b !== eb[i]) begin
                miscompares++; $display("FAIL directed%0d_bout got=%b exp=%b", i, got_b, eb[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, got_d;
        logic         rbin, got_b;
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < 25; i++) begin
            ra   = rand_wide();
            rb   = (i % 5 == 0) ? ra : rand_wide();
            rbin = 1'($urandom());
            exp  = model(ra, rb, rbin);
            run_op(ra, rb, rbin, got_d, got_b, lat);
            vectors++;
            if (lat !== LAT) begin
                miscompares++; $display("FAIL random%0d_latency got=%0d exp=%0d", i, lat, LAT);
            end
            vectors++;
            if ({got_b, got_d} !== exp) begin
                miscompares++;
                $display("FAIL random%0d_result got=%b/%h exp=%b/%h", i, got_b, got_d, exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] sa, sb, na, nb;
        logic         sbin, nbin;
        logic [W:0]   exp1, exp2;
        int           lat;
        sa = rand_wide(); sb = rand_wide(); sbin = 1'b1;
        na = rand_wide(); nb = rand_wide(); nbin = 1'b0;
        exp1 = model(sa, sb, sbin);
        exp2 = model(na, nb, nbin);
        a = sa; b = sb; bin = sbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 4 * LAT; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
        vectors++;
        if (lat !== LAT) begin
            miscompares++; $display("FAIL stall_latency got=%0d exp=%0d", lat, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = rand_wide(); b = rand_wide(); bin = 1'($urandom());
            @(posedge clk); #1;
            vectors++;
            if ({out_valid, in_ready, bout, diff} !== {1'b1, 1'b0, exp1}) begin
                miscompares++;
                $display("FAIL stall_hold%0d got=v%b r%b %b/%h exp=v1 r0 %b/%h",
                         i, out_valid, in_ready, bout, diff, exp1[W], exp1[W-1:0]);
            end
        end
        a = na; b = nb; bin = nbin; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++; $display("FAIL stall_release got=r%b v%b exp=r1 v0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL stall_next_accept got=%b exp=0", in_ready);
        end
        lat = -1;
        for (int i = 1; i <= 4 * LAT; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
        vectors++;
        if (lat !== LAT || {bout, diff} !== exp2) begin
            miscompares++;
            $display("FAIL stall_next_result got=%0d %b/%h exp=%0d %b/%h",
                     lat, bout, diff, LAT, exp2[W], exp2[W-1:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_busy();
        logic [W-1:0] got_d, exp_d;
        logic         got_b;
        int           lat;
        bit           seen;
        a = rand_wide(); b = rand_wide(); bin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({out_valid, bout, diff} !== {2'b00, {W{1'b0}}}) begin
            miscompares++; $display("FAIL rstbusy_outputs got=v%b %b/%h exp=v0 0/0", out_valid, bout, diff);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rstbusy_in_ready got=%b exp=1", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("FAIL rstbusy_no_valid got=%b exp=0", seen);
        end
        exp_d = '1;
        exp_d = exp_d - 1'b1;
        run_op(W'(7), W'(9), 1'b0, got_d, got_b, lat);
        vectors++;
        if ({lat == LAT, got_b, got_d} !== {1'b1, 1'b1, exp_d}) begin
            miscompares++; $display("FAIL rstbusy_follow got=%0d %b/%h exp=%0d 1/%h", lat, got_b, got_d, LAT, exp_d);
        end
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/binary_subtractor_seq.md
BINARY_SUBTRACTOR_SEQ -- requirements
Module: binary_subtractor_seq

Interface
REQ-001 Parameter WIDTH, 100, operand and result width in bits.
REQ-002 Parameter CHUNK, 10, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK (N = WIDTH/CHUNK).
REQ-003 Port clk input 1: single clock; all state SHALL change on its rising edge.
REQ-004 Port rst input 1: reset, synchronous and active-high.
REQ-005 Port a input WIDTH: minuend, unsigned.
REQ-006 Port b input WIDTH: subtrahend, unsigned.
REQ-007 Port bin input 1: borrow-in.
REQ-008 Port in_valid input 1: operands a, b and bin are valid.
REQ-009 Port in_ready output 1: block can accept operands.
REQ-010 Port diff output WIDTH: result, (a - b - bin) mod 2^WIDTH.
REQ-011 Port bout output 1: borrow-out, 1 iff a < b + bin, all unsigned.
REQ-012 Port out_valid output 1: diff and bout are valid.
REQ-013 Port out_ready input 1: consumer accepts the result.

Function
REQ-014 FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on in_valid=1 at an edge, the block SHALL register a, b and bin, clear the chunk index to 0, load the running borrow with bin and enter BUSY.
REQ-017 BUSY: each cycle the block SHALL compute chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) as a_k - b_k - borrow, write it into the diff register, update the running borrow and increment k.
REQ-018 BUSY SHALL last exactly N cycles; after the chunk k=N-1 edge the FSM SHALL enter DONE with bout equal to the final borrow.
REQ-019 Latency: out_valid SHALL rise exactly N cycles after the accepting edge (10 cycles at defaults).
REQ-020 DONE: diff and bout SHALL hold stable until out_valid and out_ready are both 1 at an edge; the FSM SHALL then return to IDLE.
REQ-021 The block SHALL ignore a, b, bin and in_valid in BUSY and DONE; operand changes after acceptance SHALL NOT affect the result.
REQ-022 There SHALL be no IDLE bypass: the earliest next accept is the cycle after the output handshake, so throughput is 1 op per N+2 cycles.
REQ-023 diff and bout SHALL keep their last values in IDLE until overwritten by the next operation.
REQ-024 A borrow SHALL ripple correctly across every chunk boundary, including through all N chunks.

Reset
REQ-025 While rst=1 at an edge: state=IDLE, diff=0, bout=0, out_valid=0, chunk index=0 and running borrow=0.
REQ-026 rst SHALL take priority over every other input; in_valid SHALL be ignored on any edge where rst=1.
REQ-027 Reset during BUSY or DONE SHALL abandon the operation, and out_valid SHALL NOT assert for it.
REQ-028 in_ready SHALL read 1 in the first cycle after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/BUSY/DONE) and the default WIDTH and CHUNK constants.
REQ-030 A combinational sub-module chunk_subtractor SHALL compute one CHUNK-bit difference and borrow-out from x, y and borrow-in.
REQ-031 The top level SHALL contain the FSM, the chunk index counter, the operand and result registers, and the chunk muxing.

Verification
REQ-032 a=5000, b=1234, bin=0 -> diff=3766, bout=0, out_valid exactly 10 cycles after accept.
REQ-033 a=0, b=1, bin=0 -> diff=all ones (2^100-1), bout=1.
REQ-034 a=b=2^100-1, bin=1 -> diff=all ones, bout=1 (borrow ripples through all 10 chunks).
REQ-035 a=2^99, b=1, bin=0 -> diff=2^99-1, bout=0 (borrow crosses chunk boundaries 0..9).
REQ-036 out_ready held 0 for 5 cycles in DONE while in_valid=1 with new operands -> diff/bout stable, in_ready=0, new operands ignored; after the handshake the next op is accepted the following cycle.
REQ-037 rst=1 asserted on the 4th BUSY cycle -> out_valid stays 0, outputs are 0, in_ready=1 after release; a following op (a=7, b=9, bin=0) -> diff=2^100-2, bout=1.
